// File: rtl/ascii2ps2_tx.sv
// ASCII character to PS/2 device-side transmitter: maps a character to its Set-2
// make code and sends make, F0, make as 11-bit odd-parity frames with a gap after each.
module ascii2ps2_tx #(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ascii_valid,
    input  logic [7:0] ascii_code,
    output logic       ascii_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       unmapped,
    output logic [1:0] dbg_state_o
);

    localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FRAME = 2'd1, S_GAP = 2'd2} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [1:0]     byte_q, byte_d;
    logic           half_q, half_d;
    logic [7:0]     code_q, code_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           unmapped_q, unmapped_d;
    logic           clk_q, clk_d;
    logic           data_q, data_d;

    function automatic logic [7:0] letter_code(input logic [4:0] i);
        case (i)
            5'd0:  letter_code = 8'h1C;  5'd1:  letter_code = 8'h32;
            5'd2:  letter_code = 8'h21;  5'd3:  letter_code = 8'h23;
            5'd4:  letter_code = 8'h24;  5'd5:  letter_code = 8'h2B;
            5'd6:  letter_code = 8'h34;  5'd7:  letter_code = 8'h33;
            5'd8:  letter_code = 8'h43;  5'd9:  letter_code = 8'h3B;
            5'd10: letter_code = 8'h42;  5'd11: letter_code = 8'h4B;
            5'd12: letter_code = 8'h3A;  5'd13: letter_code = 8'h31;
            5'd14: letter_code = 8'h44;  5'd15: letter_code = 8'h4D;
            5'd16: letter_code = 8'h15;  5'd17: letter_code = 8'h2D;
            5'd18: letter_code = 8'h1B;  5'd19: letter_code = 8'h2C;
            5'd20: letter_code = 8'h3C;  5'd21: letter_code = 8'h2A;
            5'd22: letter_code = 8'h1D;  5'd23: letter_code = 8'h22;
            5'd24: letter_code = 8'h35;  5'd25: letter_code = 8'h1A;
            default: letter_code = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] digit_code(input logic [3:0] i);
        case (i)
            4'd0: digit_code = 8'h45;  4'd1: digit_code = 8'h16;
            4'd2: digit_code = 8'h1E;  4'd3: digit_code = 8'h26;
            4'd4: digit_code = 8'h25;  4'd5: digit_code = 8'h2E;
            4'd6: digit_code = 8'h36;  4'd7: digit_code = 8'h3D;
            4'd8: digit_code = 8'h3E;  4'd9: digit_code = 8'h46;
            default: digit_code = 8'h00;
        endcase
    endfunction

    // Returns {hit, make_code}; clearing bit 5 folds lowercase onto uppercase.
    function automatic logic [8:0] lookup(input logic [7:0] c);
        logic [7:0] up;
        logic [7:0] off;
        up     = c & 8'hDF;
        off    = up - 8'h41;
        lookup = 9'd0;
        if (up >= 8'h41 && up <= 8'h5A) lookup = {1'b1, letter_code(off[4:0])};
        else if (c >= 8'h30 && c <= 8'h39) lookup = {1'b1, digit_code(c[3:0])};
        else if (c == 8'h20) lookup = {1'b1, 8'h29};
        else if (c == 8'h0D) lookup = {1'b1, 8'h5A};
        else if (c == 8'h08) lookup = {1'b1, 8'h66};
    endfunction

    logic [8:0]  lk;
    logic [7:0]  frame_byte;
    logic [10:0] frame_bits;
    logic        accept;

    assign lk         = lookup(ascii_code);
    assign accept     = ascii_valid && ready_q;
    assign frame_byte = (byte_q == 2'd1) ? 8'hF0 : code_q;
    assign frame_bits = {1'b1, ~^frame_byte, frame_byte, 1'b0};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        half_d     = half_q;
        code_d     = code_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        unmapped_d = 1'b0;
        clk_d      = clk_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                clk_d   = 1'b1;
                data_d  = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if (lk[8]) begin
                        state_d = S_FRAME;
                        code_d  = lk[7:0];
                        byte_d  = 2'd0;
                        bit_d   = 4'd0;
                        cnt_d   = '0;
                        half_d  = 1'b0;
                        data_d  = 1'b0;
                    end else begin
                        unmapped_d = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (cnt_q == CW'(HALF_PERIOD - 1)) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        clk_d  = 1'b0;
                    end else begin
                        half_d = 1'b0;
                        clk_d  = 1'b1;
                        if (bit_q == 4'd10) begin
                            state_d = S_GAP;
                            bit_d   = 4'd0;
                            data_d  = 1'b1;
                        end else begin
                            bit_d  = bit_q + 4'd1;
                            data_d = frame_bits[bit_d];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (byte_q == 2'd2) begin
                        state_d = S_IDLE;
                        byte_d  = 2'd0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_FRAME;
                        byte_d  = byte_q + 2'd1;
                        half_d  = 1'b0;
                        clk_d   = 1'b1;
                        data_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            byte_q     <= 2'd0;
            half_q     <= 1'b0;
            code_q     <= 8'h00;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            unmapped_q <= 1'b0;
            clk_q      <= 1'b1;
            data_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            half_q     <= half_d;
            code_q     <= code_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            unmapped_q <= unmapped_d;
            clk_q      <= clk_d;
            data_q     <= data_d;
        end
    end

    assign ascii_ready = ready_q;
    assign ps2_clk     = clk_q;
    assign ps2_data    = data_q;
    assign busy        = busy_q;
    assign unmapped    = unmapped_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ascii2ps2_tx.sv
// Bench for ascii2ps2_tx: directed characters feed an expected-byte queue that a
// PS/2 host model drains as it decodes frames off the lines.
module tb_ascii2ps2_tx;

    localparam int HP  = 4;
    localparam int GAP = 8;
    localparam int LAT = 3 * (22 * HP + GAP);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ascii_valid = 1'b0;
    logic [7:0] ascii_code = 8'h00;
    logic       ascii_ready, ps2_clk, ps2_data, busy, unmapped;
    logic [1:0] dbg_state;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    logic [7:0] chr_tab [39] = '{
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
        8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A,
        8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54,
        8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h20, 8'h0D, 8'h08};
    logic [7:0] sc_tab [39] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29, 8'h5A, 8'h66};
    logic [7:0] unm_tab [4] = '{8'h23, 8'h40, 8'h5B, 8'h7B};

    ascii2ps2_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .ascii_valid(ascii_valid), .ascii_code(ascii_code),
        .ascii_ready(ascii_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .busy(busy), .unmapped(unmapped), .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host model: samples ps2_data on each ps2_clk falling edge
    logic        prev_clk = 1'b1;
    int          nbits = 0;
    int          last_fall = 0;
    logic [10:0] sh;
    always @(negedge clk) begin
        if (!rst_n) begin
            nbits    = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk) begin
                if (nbits > 0) check("bit_period", cyc - last_fall, 2 * HP);
                last_fall = cyc;
                sh[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    check("start_bit", int'(sh[0]), 0);
                    check("stop_bit", int'(sh[10]), 1);
                    check("odd_parity", int'(^sh[9:1]), 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got %0h expected none", sh[8:1]);
                    end else begin
                        check("frame_byte", int'(sh[8:1]), int'(exp_q.pop_front()));
                    end
                    nbits = 0;
                end
            end
            prev_clk = ps2_clk;
        end
    end

    // Counts negedges with ascii_ready low, starting at the current negedge
    task automatic wait_ready(output int n);
        n = 0;
        while (!ascii_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic push_seq(input logic [7:0] sc);
        exp_q.push_back(sc);
        exp_q.push_back(8'hF0);
        exp_q.push_back(sc);
    endtask

    // Drives one character; leaves the bench on the negedge after the accepting edge
    task automatic offer(input logic [7:0] c);
        int t;
        t = 0;
        @(negedge clk);
        while (!ascii_ready && t < 1000) begin
            t++;
            @(negedge clk);
        end
        check("ready_before_send", int'(ascii_ready), 1);
        ascii_valid = 1'b1;
        ascii_code  = c;
        @(negedge clk);
        ascii_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("ready_low_after_accept", int'(ascii_ready), 0);
    endtask

    task automatic send_mapped(input logic [7:0] c, input logic [7:0] sc);
        int n;
        push_seq(sc);
        offer(c);
        check("unmapped_quiet", int'(unmapped), 0);
        wait_ready(n);
        check("ready_latency", n, LAT);
        check("busy_clear", int'(busy), 0);
    endtask

    task automatic send_unmapped(input logic [7:0] c);
        offer(c);
        check("unmapped_pulse", int'(unmapped), 1);
        check("unmapped_lines", int'({ps2_clk, ps2_data}), 3);
        @(negedge clk);
        check("unmapped_one_cycle", int'(unmapped), 0);
        check("unmapped_ready_back", int'(ascii_ready), 1);
        check("unmapped_busy_clear", int'(busy), 0);
        check("unmapped_lines_after", int'({ps2_clk, ps2_data}), 3);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ascii_ready), 0);
        check("rst_lines", int'({ps2_clk, ps2_data}), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_unmapped", int'(unmapped), 0);
        check("rst_state", int'(dbg_state), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(ascii_ready), 1);

        // 'A', 'a' and the full mapped set
        send_mapped(8'h41, 8'h1C);
        send_mapped(8'h61, 8'h1C);
        send_mapped(8'h7A, 8'h1A);
        for (int i = 0; i < 39; i++) send_mapped(chr_tab[i], sc_tab[i]);

        // Characters without a scancode
        for (int i = 0; i < 4; i++) send_unmapped(unm_tab[i]);

        // CR held valid across the transmission: exactly one back-to-back resend
        push_seq(8'h5A);
        offer(8'h0D);
        ascii_valid = 1'b1;
        wait_ready(n);
        check("held_latency", n, LAT);
        push_seq(8'h5A);
        @(negedge clk);
        check("held_reaccept", int'(ascii_ready), 0);
        check("held_busy", int'(busy), 1);
        ascii_valid = 1'b0;
        wait_ready(n);
        check("held_latency2", n, LAT);

        // Reset during bit 4 of the F0 frame
        exp_q.push_back(8'h32);
        offer(8'h42);
        repeat (130) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_lines", int'({ps2_clk, ps2_data}), 3);
        check("abort_ready", int'(ascii_ready), 0);
        check("abort_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_clk_held", int'(ps2_clk), 1);
        end
        check("abort_state", int'(dbg_state), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_release", int'(ascii_ready), 1);
        check("abort_no_resume", int'({ps2_clk, ps2_data}), 3);
        send_mapped(8'h20, 8'h29);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
